// File: rtl/rom_fifo_wr_ctrl.sv
// rtl/rom_fifo_wr_ctrl.sv - streams a ROM burst into the FIFO write port, absorbing ROM latency in a skid buffer
// Optional back-to-back burst mode: define ROM_FIFO_CTRL_LOOP_EN (adds input stop).
module rom_fifo_wr_ctrl #(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 16,
    parameter int LEN_W   = 7,
    parameter int ROM_LAT = 1
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  burst_len,
`ifdef ROM_FIFO_CTRL_LOOP_EN
    input  logic              stop,
`endif
    output logic [ADDR_W-1:0] rom_addra,
    input  logic [DATA_W-1:0] rom_douta,
    input  logic              fifo_full,
    input  logic              fifo_wr_rst_busy,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_din,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  words_written
);
    localparam int SKID_D = ROM_LAT + 1;
    localparam int CNT_W  = $clog2(SKID_D + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RUN, S_DONE} state_t;

    state_t             state;
    logic [ADDR_W-1:0]  addr;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   issued;
    logic [ROM_LAT-1:0] pipe;
    logic [DATA_W-1:0]  skid [0:SKID_D];
    logic [CNT_W-1:0]   skid_cnt;
    logic [CNT_W-1:0]   inflight;
    logic [CNT_W-1:0]   after_pop;
    logic [CNT_W-1:0]   pending;
    logic               issue;
    logic               push;
    logic               burst_end;
    logic               reload;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < ROM_LAT; i++) begin
            inflight = inflight + CNT_W'(pipe[i]);
        end
    end

    assign push       = pipe[ROM_LAT-1];
    assign fifo_wr_en = (skid_cnt != '0) && !fifo_full && !fifo_wr_rst_busy;
    assign after_pop  = skid_cnt - CNT_W'(fifo_wr_en);
    // Counting this cycle's pop as a freed credit keeps one word per cycle when unstalled.
    assign pending    = inflight + after_pop;
    assign issue      = (state == S_RUN) && (issued < len) && (pending < CNT_W'(SKID_D));
    assign burst_end  = (state == S_RUN) && (issued == len) && (inflight == '0) && (after_pop == '0);
    assign rom_addra  = addr;
    assign fifo_din   = skid[0];

`ifdef ROM_FIFO_CTRL_LOOP_EN
    logic stop_req;

    always_ff @(posedge sys_clk) begin
        if (rst || state == S_IDLE) begin
            stop_req <= 1'b0;
        end else if (stop) begin
            stop_req <= 1'b1;
        end
    end

    assign reload = !(stop_req || stop);
`else
    assign reload = 1'b0;
`endif

    // Skid is a shift queue: entry 0 is the head, pushes land just behind the last valid entry.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            pipe     <= '0;
            skid_cnt <= '0;
            for (int i = 0; i <= SKID_D; i++) begin
                skid[i] <= '0;
            end
        end else begin
            pipe     <= (pipe << 1) | ROM_LAT'(issue);
            skid_cnt <= after_pop + CNT_W'(push);
            for (int i = 0; i < SKID_D; i++) begin
                if (push && CNT_W'(i) == after_pop) begin
                    skid[i] <= rom_douta;
                end else if (fifo_wr_en) begin
                    skid[i] <= skid[i+1];
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state         <= S_IDLE;
            addr          <= '0;
            len           <= '0;
            issued        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            words_written <= '0;
        end else begin
            if (fifo_wr_en) begin
                words_written <= words_written + LEN_W'(1);
            end
            if (issue) begin
                addr   <= addr + ADDR_W'(1);
                issued <= issued + LEN_W'(1);
            end
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        addr          <= start_addr;
                        len           <= burst_len;
                        issued        <= '0;
                        words_written <= '0;
                        busy          <= 1'b1;
                        state         <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!fifo_wr_rst_busy) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (burst_end) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done <= 1'b0;
                    if (reload) begin
                        addr          <= start_addr;
                        len           <= burst_len;
                        issued        <= '0;
                        words_written <= '0;
                        busy          <= 1'b1;
                        state         <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rom_fifo_wr_ctrl.sv
// tb/tb_rom_fifo_wr_ctrl.sv - directed bench driving ROM_LAT=1 and ROM_LAT=2 instances with shared stimulus
module tb_rom_fifo_wr_ctrl;
    localparam int AW = 6;
    localparam int DW = 16;
    localparam int LW = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [LW-1:0] burst_len = '0;
    logic          fifo_full = 1'b0;
    logic          wr_busy = 1'b0;
`ifdef ROM_FIFO_CTRL_LOOP_EN
    logic          stop = 1'b1;
`endif

    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] dout_a, dout_b, din_a, din_b;
    logic          wr_a, wr_b, busy_a, busy_b, done_a, done_b;
    logic [LW-1:0] ww_a, ww_b;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int tbusy = 0;

    function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
        return {a, 4'h5, ~a};
    endfunction

    logic [DW-1:0] a_r1, b_r1, b_r2;
    always @(posedge clk) begin
        a_r1 <= rom_f(addr_a);
        b_r1 <= rom_f(addr_b);
        b_r2 <= b_r1;
    end
    assign dout_a = a_r1;
    assign dout_b = b_r2;

    rom_fifo_wr_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .ROM_LAT(1)) dut_a (
        .sys_clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .burst_len(burst_len),
`ifdef ROM_FIFO_CTRL_LOOP_EN
        .stop(stop),
`endif
        .rom_addra(addr_a), .rom_douta(dout_a), .fifo_full(fifo_full), .fifo_wr_rst_busy(wr_busy),
        .fifo_wr_en(wr_a), .fifo_din(din_a), .busy(busy_a), .done(done_a), .words_written(ww_a)
    );

    rom_fifo_wr_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .ROM_LAT(2)) dut_b (
        .sys_clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .burst_len(burst_len),
`ifdef ROM_FIFO_CTRL_LOOP_EN
        .stop(stop),
`endif
        .rom_addra(addr_b), .rom_douta(dout_b), .fifo_full(fifo_full), .fifo_wr_rst_busy(wr_busy),
        .fifo_wr_en(wr_b), .fifo_din(din_b), .busy(busy_b), .done(done_b), .words_written(ww_b)
    );

    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];
    int dna = 0, dnb = 0, fa = -1, fb = -1, la = -1, lb = -1, dca = -1, dcb = -1;
    int busy_at_done = 0;
    int max_pend = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (wr_a) begin qa.push_back(din_a); if (fa < 0) fa = cyc; la = cyc; end
        if (wr_b) begin qb.push_back(din_b); if (fb < 0) fb = cyc; lb = cyc; end
        if (done_a) begin dna++; dca = cyc; if (busy_a) busy_at_done++; end
        if (done_b) begin dnb++; dcb = cyc; if (busy_b) busy_at_done++; end
        if (int'(dut_b.inflight) + int'(dut_b.skid_cnt) > max_pend)
            max_pend = int'(dut_b.inflight) + int'(dut_b.skid_cnt);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        qa.delete(); qb.delete();
        dna = 0; dnb = 0; fa = -1; fb = -1; la = -1; lb = -1; dca = -1; dcb = -1;
        max_pend = 0;
    endtask

    task automatic go(input logic [AW-1:0] a, input logic [LW-1:0] l);
        start_addr = a; burst_len = l; start = 1'b1;
        tick();
        start = 1'b0;
        tbusy = cyc;
    endtask

    task automatic wait_both(input int lim);
        int n = 0;
        while (!(dna > 0 && dnb > 0) && n < lim) begin tick(); n++; end
        chk("done_timeout", 32'(dna > 0 && dnb > 0), 1);
        repeat (5) tick();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_addr_a"}, 32'(addr_a), 0); chk({tag, "_addr_b"}, 32'(addr_b), 0);
        chk({tag, "_wr_a"}, 32'(wr_a), 0);     chk({tag, "_wr_b"}, 32'(wr_b), 0);
        chk({tag, "_din_a"}, 32'(din_a), 0);   chk({tag, "_din_b"}, 32'(din_b), 0);
        chk({tag, "_busy_a"}, 32'(busy_a), 0); chk({tag, "_busy_b"}, 32'(busy_b), 0);
        chk({tag, "_done_a"}, 32'(done_a), 0); chk({tag, "_done_b"}, 32'(done_b), 0);
        chk({tag, "_ww_a"}, 32'(ww_a), 0);     chk({tag, "_ww_b"}, 32'(ww_b), 0);
    endtask

    task automatic chk_data(input string tag, input logic [AW-1:0] a0, input int n);
        logic [AW-1:0] a;
        chk({tag, "_cnt_a"}, qa.size(), n);
        chk({tag, "_cnt_b"}, qb.size(), n);
        a = a0;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_data_a"}, 32'(qa[i]), 32'(rom_f(a)));
            chk({tag, "_data_b"}, 32'(qb[i]), 32'(rom_f(a)));
            a = a + AW'(1);
        end
    endtask

    initial begin
        int n;
        int sa, sb;
        repeat (3) tick();
        chk_zero("reset");
        rst = 1'b0;
        tick();

        // 8-word burst from address 0, unstalled
        clear();
        go(6'd0, 7'd8);
        chk("t1_busy_a", 32'(busy_a), 1);
        chk("t1_busy_b", 32'(busy_b), 1);
        wait_both(100);
        chk_data("t1", 6'd0, 8);
        chk("t1_first_a", fa, tbusy + 3);
        chk("t1_first_b", fb, tbusy + 4);
        chk("t1_span_a", la - fa, 7);
        chk("t1_span_b", lb - fb, 7);
        chk("t1_done_at_a", dca, la + 1);
        chk("t1_done_at_b", dcb, lb + 1);
        chk("t1_done_cnt_a", dna, 1);
        chk("t1_done_cnt_b", dnb, 1);
        chk("t1_ww_a", 32'(ww_a), 8);
        chk("t1_ww_b", 32'(ww_b), 8);

        // address wrap 62,63,0,1
        clear();
        go(6'd62, 7'd4);
        wait_both(100);
        chk_data("t2", 6'd62, 4);
        chk("t2_ww_b", 32'(ww_b), 4);

        // zero-length burst
        clear();
        go(6'd9, 7'd0);
        chk("t3_busy_a", 32'(busy_a), 1);
        wait_both(20);
        chk("t3_cnt_a", qa.size(), 0);
        chk("t3_cnt_b", qb.size(), 0);
        chk("t3_ww_a", 32'(ww_a), 0);
        chk("t3_done_cnt_a", dna, 1);
        chk("t3_done_at_a", dca, tbusy + 2);
        chk("busy_at_done", busy_at_done, 0);

        // full asserted for 5 cycles after the 3rd ROM_LAT=2 write
        clear();
        go(6'd20, 7'd16);
        n = 0;
        while (qb.size() < 3 && n < 50) begin tick(); n++; end
        chk("t4_third_timeout", 32'(qb.size() >= 3), 1);
        fifo_full = 1'b1;
        repeat (5) tick();
        fifo_full = 1'b0;
        wait_both(200);
        chk_data("t4", 6'd20, 16);
        chk("t4_pending_max", 32'(max_pend <= 3), 1);
        chk("t4_ww_a", 32'(ww_a), 16);
        chk("t4_ww_b", 32'(ww_b), 16);

        // write-side reset busy holds off issue, then reset mid-burst
        clear();
        wr_busy = 1'b1;
        go(6'd5, 7'd12);
        for (int i = 0; i < 10; i++) begin
            chk("t5_hold_addr_a", 32'(addr_a), 5);
            chk("t5_hold_addr_b", 32'(addr_b), 5);
            tick();
        end
        chk("t5_hold_cnt_a", qa.size(), 0);
        chk("t5_hold_busy_a", 32'(busy_a), 1);
        wr_busy = 1'b0;
        n = 0;
        while (qa.size() < 5 && n < 50) begin tick(); n++; end
        chk("t5_fifth_timeout", 32'(qa.size() >= 5), 1);
        rst = 1'b1;
        tick();
        sa = qa.size();
        sb = qb.size();
        chk_zero("t5_rst");
        rst = 1'b0;
        repeat (10) tick();
        chk("t5_after_rst_a", qa.size(), sa);
        chk("t5_after_rst_b", qb.size(), sb);
        for (int i = 0; i < 5; i++) chk("t5_data_a", 32'(qa[i]), 32'(rom_f(AW'(5 + i))));

`ifdef ROM_FIFO_CTRL_LOOP_EN
        clear();
        stop = 1'b0;
        go(6'd0, 7'd4);
        n = 0;
        while (dna < 1 && n < 50) begin tick(); n++; end
        stop = 1'b1;
        n = 0;
        while (dna < 2 && n < 50) begin tick(); n++; end
        repeat (10) tick();
        chk("loop_cnt_a", qa.size(), 8);
        chk("loop_cnt_b", qb.size(), 8);
        chk("loop_done_a", dna, 2);
        chk("loop_done_b", dnb, 2);
        chk("loop_idle_a", 32'(busy_a), 0);
        for (int i = 0; i < 8; i++) chk("loop_data_a", 32'(qa[i]), 32'(rom_f(AW'(i % 4))));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
